cmd_dispatch: RTL and testbench

CMD_DISPATCH -- requirements
Module: cmd_dispatch

---
 rtl/cmd_dispatch_if.sv | 15 +
 rtl/cmd_dispatch.sv | 78 +++++++
 tb/tb_cmd_dispatch.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cmd_dispatch_if.sv
// cmd_dispatch_if: command receiver, transmitter, datapath and config signals of cmd_dispatch
interface cmd_dispatch_if;
  logic        cmd_rdy;
  logic [15:0] cmd;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        go;
  logic        done;
  logic [31:0] cfg;
  logic        busy;
  modport master (output cmd_rdy, cmd, tx_done, done, input clr_cmd_rdy, trmt, tx_data, go, cfg, busy);
  modport slave (input cmd_rdy, cmd, tx_done, done, output clr_cmd_rdy, trmt, tx_data, go, cfg, busy);
endinterface

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: decodes UART commands into config writes/reads and datapath GO runs, sending one response byte each
module cmd_dispatch #(
  parameter int TIMEOUT_CYC = 50000
) (
  input logic clk,
  input logic rst_n,
  cmd_dispatch_if.slave bus
);
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, EXEC, WAIT_DONE, SEND, WAIT_TX} state_t;
  state_t state;
  logic [3:0] op_q;
  logic [1:0] addr_q;
  logic [7:0] data_q;
  logic [CW-1:0] cnt;
  logic [31:0] cfg_q;
  logic [7:0] tx_q;
  // pulses are decoded from state so reset forces them low immediately
  assign bus.clr_cmd_rdy = rst_n && state == IDLE && bus.cmd_rdy;
  assign bus.go = state == EXEC && op_q == 4'h3;
  assign bus.trmt = state == SEND;
  assign bus.busy = state != IDLE;
  assign bus.cfg = cfg_q;
  assign bus.tx_data = tx_q;
  // command sequencing, config registers, timeout counter and response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      cnt <= '0;
      cfg_q <= '0;
      tx_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_rdy) begin
          op_q <= bus.cmd[15:12];
          addr_q <= bus.cmd[9:8];
          data_q <= bus.cmd[7:0];
          state <= EXEC;
        end
        EXEC: begin
          case (op_q)
            4'h1: begin
              cfg_q[{addr_q, 3'b000} +: 8] <= data_q;
              tx_q <= 8'hA5;
              state <= SEND;
            end
            4'h2: begin
              tx_q <= cfg_q[{addr_q, 3'b000} +: 8];
              state <= SEND;
            end
            4'h3: begin
              cnt <= '0;
              state <= WAIT_DONE;
            end
            default: begin
              tx_q <= 8'hFF;
              state <= SEND;
            end
          endcase
        end
        WAIT_DONE: begin
          if (bus.done || cnt == CNT_MAX) begin
            tx_q <= bus.done ? 8'hA5 : 8'hEE;
            state <= SEND;
          end else
            cnt <= cnt + 1'b1;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: if (bus.tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: randomized and directed checks of cmd_dispatch (default and 8-cycle timeout) against a byte-level model
module tb_cmd_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic rdy_v[2], txd_v[2], done_v[2];
  logic [15:0] cmd_v[2];
  logic clr_o[2], trmt_o[2], go_o[2], busy_o[2];
  logic [7:0] tx_o[2];
  logic [31:0] cfg_o[2];
  logic [7:0] cfg_m[2][4];
  int total = 0;
  int bad = 0;
  cmd_dispatch_if bus0();
  cmd_dispatch_if bus1();
  cmd_dispatch u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cmd_dispatch #(.TIMEOUT_CYC(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  assign bus0.cmd_rdy = rdy_v[0];
  assign bus0.cmd = cmd_v[0];
  assign bus0.tx_done = txd_v[0];
  assign bus0.done = done_v[0];
  assign bus1.cmd_rdy = rdy_v[1];
  assign bus1.cmd = cmd_v[1];
  assign bus1.tx_done = txd_v[1];
  assign bus1.done = done_v[1];
  assign clr_o[0] = bus0.clr_cmd_rdy;
  assign trmt_o[0] = bus0.trmt;
  assign go_o[0] = bus0.go;
  assign busy_o[0] = bus0.busy;
  assign tx_o[0] = bus0.tx_data;
  assign cfg_o[0] = bus0.cfg;
  assign clr_o[1] = bus1.clr_cmd_rdy;
  assign trmt_o[1] = bus1.trmt;
  assign go_o[1] = bus1.go;
  assign busy_o[1] = bus1.busy;
  assign tx_o[1] = bus1.tx_data;
  assign cfg_o[1] = bus1.cfg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input int u);
    chk("rst_busy", 32'(busy_o[u]), 0);
    chk("rst_trmt", 32'(trmt_o[u]), 0);
    chk("rst_go", 32'(go_o[u]), 0);
    chk("rst_clr", 32'(clr_o[u]), 0);
    chk("rst_tx", 32'(tx_o[u]), 0);
    chk("rst_cfg", cfg_o[u], 0);
  endtask

  // one complete command on instance u; dly = cycles in WAIT_DONE before done (negative: never)
  task automatic do_cmd(input int u, input logic [15:0] c, input int dly, input bit pend, input logic [15:0] nc);
    logic [7:0] rsp;
    int t, last, a;
    t = u ? 8 : 50000;
    a = int'(c[9:8]);
    case (c[15:12])
      4'h1: begin cfg_m[u][a] = c[7:0]; rsp = 8'hA5; end
      4'h2: rsp = cfg_m[u][a];
      4'h3: rsp = (dly >= 0 && dly < t) ? 8'hA5 : 8'hEE;
      default: rsp = 8'hFF;
    endcase
    rdy_v[u] = 1'b1;
    cmd_v[u] = c;
    #1;
    chk("idle_clr", 32'(clr_o[u]), 1);
    chk("idle_busy", 32'(busy_o[u]), 0);
    tick;
    rdy_v[u] = 1'b0;
    chk("exec_busy", 32'(busy_o[u]), 1);
    chk("exec_clr", 32'(clr_o[u]), 0);
    chk("exec_go", 32'(go_o[u]), 32'(c[15:12] == 4'h3));
    chk("exec_trmt", 32'(trmt_o[u]), 0);
    tick;
    if (c[15:12] == 4'h3) begin
      last = (dly >= 0 && dly < t) ? dly : t - 1;
      for (int k = 0; k <= last; k++) begin
        done_v[u] = (k == dly);
        txd_v[u] = 1'($urandom);
        chk("wd_go", 32'(go_o[u]), 0);
        chk("wd_trmt", 32'(trmt_o[u]), 0);
        chk("wd_busy", 32'(busy_o[u]), 1);
        tick;
      end
      done_v[u] = 1'b0;
      txd_v[u] = 1'b0;
    end
    chk("send_trmt", 32'(trmt_o[u]), 1);
    chk("send_tx", 32'(tx_o[u]), 32'(rsp));
    chk("send_go", 32'(go_o[u]), 0);
    done_v[u] = 1'b1;
    tick;
    chk("wtx_trmt", 32'(trmt_o[u]), 0);
    chk("wtx_tx", 32'(tx_o[u]), 32'(rsp));
    repeat ($urandom_range(0, 3)) begin
      chk("wtx_busy", 32'(busy_o[u]), 1);
      tick;
    end
    if (pend) begin
      rdy_v[u] = 1'b1;
      cmd_v[u] = nc;
      #1;
      chk("wtx_pend_clr", 32'(clr_o[u]), 0);
    end
    txd_v[u] = 1'b1;
    tick;
    txd_v[u] = 1'b0;
    done_v[u] = 1'b0;
    chk("end_busy", 32'(busy_o[u]), 0);
    chk("end_trmt", 32'(trmt_o[u]), 0);
    chk("end_cfg", cfg_o[u], {cfg_m[u][3], cfg_m[u][2], cfg_m[u][1], cfg_m[u][0]});
  endtask

  initial begin
    logic [15:0] c;
    logic [3:0] op;
    int u, dly;
    for (int i = 0; i < 2; i++) begin
      rdy_v[i] = 1'b0;
      txd_v[i] = 1'b0;
      done_v[i] = 1'b0;
      cmd_v[i] = '0;
      for (int j = 0; j < 4; j++) cfg_m[i][j] = '0;
    end
    rdy_v[1] = 1'b1;
    repeat (2) tick;
    check_reset_outputs(0);
    check_reset_outputs(1);
    rdy_v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    do_cmd(1, 16'h123C, -1, 1'b0, 16'h0);
    chk("write_cfg2", 32'(cfg_o[1][23:16]), 32'h3C);
    do_cmd(1, 16'h2200, -1, 1'b0, 16'h0);
    do_cmd(0, 16'h3000, 10, 1'b0, 16'h0);
    do_cmd(1, 16'h3000, -1, 1'b0, 16'h0);
    do_cmd(1, 16'h3000, 7, 1'b0, 16'h0);
    do_cmd(1, 16'hF000, -1, 1'b1, 16'h2200);
    do_cmd(1, 16'h2200, -1, 1'b0, 16'h0);
    repeat (40) begin
      u = int'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: op = 4'h1;
        1: op = 4'h2;
        2: op = 4'h3;
        default: op = 4'($urandom);
      endcase
      c = {op, 12'($urandom)};
      dly = u == 1 ? int'($urandom_range(0, 11)) - 1 : int'($urandom_range(0, 20));
      do_cmd(u, c, dly, 1'b0, 16'h0);
    end
    rdy_v[1] = 1'b1;
    cmd_v[1] = 16'h3000;
    tick;
    rdy_v[1] = 1'b0;
    repeat (3) tick;
    chk("pre_rst_busy", 32'(busy_o[1]), 1);
    rdy_v[1] = 1'b1;
    cmd_v[1] = 16'h2100;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1);
    check_reset_outputs(0);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) cfg_m[i][j] = '0;
    repeat (3) begin
      tick;
      chk("in_rst_trmt", 32'(trmt_o[1]), 0);
      chk("in_rst_go", 32'(go_o[1]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(1, 16'h2100, -1, 1'b0, 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
